// File: rtl/wb_rr_watchdog_arbiter_if.sv
// Bundle of the signals between the masters' cyc lines, the shared slave bus and the arbiter.
// The slave modport is the arbiter's view; the master modport is the requesting side.
interface wb_rr_watchdog_arbiter_if #(
    parameter int MASTER_COUNT = 2,
    parameter int GNT_WIDTH    = $clog2(MASTER_COUNT)
);
    logic [MASTER_COUNT-1:0] cyc_i;
    logic                    stb_i;
    logic                    ack_i;
    logic                    err_i;
    logic                    rty_i;
    logic [GNT_WIDTH-1:0]    gnt_o;
    logic                    cyc_o;
    logic                    timeout_err_o;
    logic                    busy_o;

    modport slave (
        input  cyc_i, stb_i, ack_i, err_i, rty_i,
        output gnt_o, cyc_o, timeout_err_o, busy_o
    );

    modport master (
        output cyc_i, stb_i, ack_i, err_i, rty_i,
        input  gnt_o, cyc_o, timeout_err_o, busy_o
    );
endinterface

// File: rtl/wb_rr_watchdog_arbiter.sv
// Round-robin Wishbone bus arbiter with a per-transfer watchdog that forces an
// error termination when a strobed transfer gets no slave response in time.
module wb_rr_watchdog_arbiter #(
    parameter int MASTER_COUNT = 2,
    parameter int GNT_WIDTH    = $clog2(MASTER_COUNT),
    parameter int TIMEOUT      = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    wb_rr_watchdog_arbiter_if.slave        bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [GNT_WIDTH-1:0] LAST_RST = GNT_WIDTH'(MASTER_COUNT - 1);

    state_t               state_q, state_d;
    logic [GNT_WIDTH-1:0] gnt_q, gnt_d;
    logic [GNT_WIDTH-1:0] last_q, last_d;

    logic [GNT_WIDTH-1:0]    cand_idx [MASTER_COUNT];
    logic [MASTER_COUNT-1:0] cand_req;
    logic [GNT_WIDTH-1:0]    pick_idx;
    logic                    any_req;
    logic                    cyc_granted;
    logic                    cyc_out;
    logic                    busy_out;
    logic                    timeout_out;

    // Candidate gi is the master gi+1 positions after the last winner, so
    // the last winner itself is examined last.
    for (genvar gi = 0; gi < MASTER_COUNT; gi++) begin : g_cand
        assign cand_idx[gi] = GNT_WIDTH'((int'(last_q) + gi + 1) % MASTER_COUNT);
        assign cand_req[gi] = bus.cyc_i[cand_idx[gi]];
    end

    assign any_req = |bus.cyc_i;

    always_comb begin
        pick_idx = cand_idx[0];
        for (int i = MASTER_COUNT - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                pick_idx = cand_idx[i];
            end
        end
    end

    assign cyc_granted = bus.cyc_i[gnt_q];

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        cyc_out  = 1'b0;
        busy_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = pick_idx;
                    last_d  = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                busy_out = 1'b1;
                // Pass cyc straight through so the slave sees the drop in the same cycle.
                cyc_out  = cyc_granted;
                if (!cyc_granted) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    if (TIMEOUT > 0) begin : g_wdog
        localparam int CNT_W = $clog2(TIMEOUT + 1);

        logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
        logic             stalled;
        logic             expire;

        // cyc_out is only ever high in GRANT, which keeps the watchdog quiet in IDLE.
        assign stalled     = cyc_out & bus.stb_i & ~(bus.ack_i | bus.err_i | bus.rty_i);
        assign expire      = stalled && (stall_cnt_q == CNT_W'(TIMEOUT));
        assign stall_cnt_d = (stalled && !expire) ? stall_cnt_q + 1'b1 : '0;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                stall_cnt_q <= '0;
            end else begin
                stall_cnt_q <= stall_cnt_d;
            end
        end

        assign timeout_out = expire;
    end else begin : g_no_wdog
        assign timeout_out = 1'b0;
    end

    assign bus.gnt_o         = gnt_q;
    assign bus.cyc_o         = cyc_out;
    assign bus.busy_o        = busy_out;
    assign bus.timeout_err_o = timeout_out;
endmodule

// File: tb/tb_wb_rr_watchdog_arbiter.sv
// Directed bench for the round-robin watchdog arbiter: one instance with TIMEOUT=4
// and one with the watchdog disabled, three masters each.
module tb_wb_rr_watchdog_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wb_rr_watchdog_arbiter_if #(.MASTER_COUNT(3), .GNT_WIDTH(2)) bus4 ();
    wb_rr_watchdog_arbiter_if #(.MASTER_COUNT(3), .GNT_WIDTH(2)) bus0 ();

    wb_rr_watchdog_arbiter #(.MASTER_COUNT(3), .GNT_WIDTH(2), .TIMEOUT(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus4)
    );

    wb_rr_watchdog_arbiter #(.MASTER_COUNT(3), .GNT_WIDTH(2), .TIMEOUT(0)) dut_nowd (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("check %s: got=%0h ok", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic s, input logic a,
                         input logic e, input logic r);
        bus4.cyc_i = c;
        bus4.stb_i = s;
        bus4.ack_i = a;
        bus4.err_i = e;
        bus4.rty_i = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [2:0] mask;
        logic [7:0] stb_pat;
        int         pulses;

        bus0.cyc_i = '0;
        bus0.stb_i = 1'b0;
        bus0.ack_i = 1'b0;
        bus0.err_i = 1'b0;
        bus0.rty_i = 1'b0;
        do_reset();
        settle();
        check("rst_cyc_o", 32'(bus4.cyc_o), 32'd0);
        check("rst_gnt_o", 32'(bus4.gnt_o), 32'd0);
        check("rst_busy_o", 32'(bus4.busy_o), 32'd0);
        check("rst_timeout", 32'(bus4.timeout_err_o), 32'd0);

        // Arbitration latency and same-cycle cyc drop.
        drive(3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("t1_c0_cyc_o", 32'(bus4.cyc_o), 32'd0);
        tick();
        settle();
        check("t1_c1_gnt_o", 32'(bus4.gnt_o), 32'd1);
        check("t1_c1_cyc_o", 32'(bus4.cyc_o), 32'd1);
        check("t1_c1_busy_o", 32'(bus4.busy_o), 32'd1);
        drive(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("t1_drop_cyc_o", 32'(bus4.cyc_o), 32'd0);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        settle();
        check("t1_idle_busy_o", 32'(bus4.busy_o), 32'd0);
        check("t1_idle_gnt_hold", 32'(bus4.gnt_o), 32'd1);

        // Rotation with all masters requesting.
        do_reset();
        drive(3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            settle();
            check($sformatf("t2_gnt_%0d", k), 32'(bus4.gnt_o), 32'(k % 3));
            check($sformatf("t2_busy_%0d", k), 32'(bus4.busy_o), 32'd1);
            drive(3'b111, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            mask = 3'b111 & ~(3'b001 << (k % 3));
            drive(mask, 1'b0, 1'b0, 1'b0, 1'b0);
            settle();
            check($sformatf("t2_drop_cyc_%0d", k), 32'(bus4.cyc_o), 32'd0);
            tick();
            settle();
            check($sformatf("t2_idle_busy_%0d", k), 32'(bus4.busy_o), 32'd0);
            drive(3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Watchdog fires on the 5th consecutive stalled cycle, then re-arms.
        do_reset();
        drive(3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        settle();
        check("t3_gnt_o", 32'(bus4.gnt_o), 32'd0);
        drive(3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 10; j++) begin
            settle();
            check($sformatf("t3_stall_%0d", j), 32'(bus4.timeout_err_o), 32'(j % 5 == 0));
            tick();
        end
        drive(3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 6; j++) begin
            settle();
            check($sformatf("t3_nostb_%0d", j), 32'(bus4.timeout_err_o), 32'd0);
            tick();
        end

        // A response (ack, err, rty in turn) in the would-be timeout cycle wins.
        for (int r = 0; r < 3; r++) begin
            drive(3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
            for (int j = 1; j <= 4; j++) begin
                settle();
                check($sformatf("t4_r%0d_stall_%0d", r, j), 32'(bus4.timeout_err_o), 32'd0);
                tick();
            end
            drive(3'b001, 1'b1, r == 0, r == 1, r == 2);
            settle();
            check($sformatf("t4_r%0d_resp", r), 32'(bus4.timeout_err_o), 32'd0);
            tick();
        end
        drive(3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 5; j++) begin
            settle();
            check($sformatf("t4_after_stall_%0d", j), 32'(bus4.timeout_err_o), 32'(j == 5));
            tick();
        end

        // A strobe gap restarts the count.
        stb_pat = 8'b1111_1011;
        for (int j = 0; j < 8; j++) begin
            drive(3'b001, stb_pat[j], 1'b0, 1'b0, 1'b0);
            settle();
            check($sformatf("t5_pat_%0d", j), 32'(bus4.timeout_err_o), 32'(j == 7));
            tick();
        end

        // Strobe with no cyc in IDLE never times out.
        drive(3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int j = 0; j < 6; j++) begin
            settle();
            check($sformatf("t5_idle_%0d", j), 32'(bus4.timeout_err_o | bus4.busy_o), 32'd0);
            tick();
        end

        // Reset mid-tenure of master 2.
        do_reset();
        drive(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        settle();
        check("t6_gnt2", 32'(bus4.gnt_o), 32'd2);
        drive(3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("t6_pre_rst_cyc_o", 32'(bus4.cyc_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("t6_rst_cyc_o", 32'(bus4.cyc_o), 32'd0);
        check("t6_rst_gnt_o", 32'(bus4.gnt_o), 32'd0);
        check("t6_rst_busy_o", 32'(bus4.busy_o), 32'd0);
        tick();
        settle();
        check("t6_regrant_gnt", 32'(bus4.gnt_o), 32'd0);
        check("t6_regrant_cyc_o", 32'(bus4.cyc_o), 32'd1);

        // Reset mid-tenure of master 1 restores the pointer so master 1 wins over 2.
        drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        settle();
        check("t6b_gnt1", 32'(bus4.gnt_o), 32'd1);
        drive(3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("t6b_rst_busy_o", 32'(bus4.busy_o), 32'd0);
        tick();
        settle();
        check("t6b_regrant_gnt", 32'(bus4.gnt_o), 32'd1);

        // Watchdog disabled: a long stall never errors.
        bus0.cyc_i = 3'b001;
        bus0.stb_i = 1'b1;
        tick();
        settle();
        check("t7_busy_o", 32'(bus0.busy_o), 32'd1);
        pulses = 0;
        repeat (1000) begin
            settle();
            if (bus0.timeout_err_o) pulses++;
            tick();
        end
        check("t7_pulses", 32'(pulses), 32'd0);
        check("t7_cyc_o", 32'(bus0.cyc_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
